// File: rtl/rx_drain_if.sv
// FIFO read-port and output-stream bundle for rx_drain_ctrl.
// The master is the drain controller; the slave is the FIFO plus the stream consumer.
interface rx_drain_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LW = $clog2(DEPTH);

    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] fifo_rd_data_i;
    logic             fifo_empty_i;
    logic [LW:0]      fifo_level_i;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i;

    modport master (
        output fifo_rd_en_o, m_valid_o, m_data_o,
        input  fifo_rd_data_i, fifo_empty_i, fifo_level_i, m_ready_i
    );

    modport slave (
        input  fifo_rd_en_o, m_valid_o, m_data_o,
        output fifo_rd_data_i, fifo_empty_i, fifo_level_i, m_ready_i
    );
endinterface

// File: rtl/rx_drain_ctrl.sv
// Drains a non-FWFT RX FIFO into a valid/ready stream through a 2-entry buffer,
// with a watermark request, total occupancy report and a discard-everything flush.
module rx_drain_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned LW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_i,
    input  logic          flush_i,
    input  logic [LW:0]   watermark_i,
    rx_drain_if.master    bus,
    output logic          dma_req_o,
    output logic [LW+1:0] occupancy_o,
    output logic          flush_busy_o
);
    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             dma_req_q, dma_req_d;
    logic             pop;
    logic             push;
    logic             rd_en;
    logic [2:0]       need;
    logic [LW+1:0]    occ;

    // Next-state, read issue and buffer update.
    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        pop     = (cnt_q != 2'd0) && (state_q != ST_FLUSH) && bus.m_ready_i;
        push    = rd_pend_q && (state_q != ST_FLUSH);
        need    = 3'(cnt_q) + 3'(rd_pend_q) - 3'(pop);

        case (state_q)
            ST_DISABLED: begin
                if (flush_i)       state_d = ST_FLUSH;
                else if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en = !bus.fifo_empty_i && (need < 3'd2);
                if (flush_i)        state_d = ST_FLUSH;
                else if (!enable_i) state_d = ST_DISABLED;
            end
            ST_FLUSH: begin
                rd_en = !bus.fifo_empty_i;
                if (bus.fifo_empty_i && !rd_pend_q)
                    state_d = enable_i ? ST_RUN : ST_DISABLED;
            end
            default: state_d = ST_DISABLED;
        endcase

        // A read issued during reset would pop a word nobody is waiting for.
        if (reset) rd_en = 1'b0;

        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = bus.fifo_rd_data_i;
                else               buf1_d = bus.fifo_rd_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = bus.fifo_rd_data_i;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_rd_data_i;
                end
            end
            default: ;
        endcase

        // Entering or staying in flush discards everything buffered, including a landing word.
        if (state_d == ST_FLUSH) cnt_d = 2'd0;

        rd_pend_d = rd_en;
        occ       = (LW+2)'(bus.fifo_level_i) + (LW+2)'(rd_pend_q) + (LW+2)'(cnt_q);
        dma_req_d = (state_q == ST_RUN) && (watermark_i != '0) &&
                    (occ >= (LW+2)'(watermark_i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DISABLED;
            buf0_q    <= '0;
            buf1_q    <= '0;
            cnt_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            dma_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            dma_req_q <= dma_req_d;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = (cnt_q != 2'd0) && (state_q != ST_FLUSH);
    assign bus.m_data_o     = buf0_q;
    assign dma_req_o        = dma_req_q;
    assign occupancy_o      = occ;
    assign flush_busy_o     = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Self-checking bench for rx_drain_ctrl: behavioural non-FWFT FIFO, stream scoreboard,
// a watermark vector table and directed latency/backpressure/flush/reset sequences.
module tb_rx_drain_ctrl;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 4;

    typedef struct {
        logic          en;
        logic [LW:0]   wm;
        logic          exp_dma;
        logic [LW+1:0] exp_occ;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [LW:0]   wm = '0;
    logic          ready = 1'b0;
    logic          dma;
    logic [LW+1:0] occ;
    logic          busy;

    logic          wr_en = 1'b0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   fq[$];
    logic [31:0]   rdata = '0;
    int            fcnt = 0;
    int            rd_cnt = 0;
    int            underrun = 0;

    logic [31:0]   sbq[$];
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    rx_drain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rx_drain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .flush_i      (flush),
        .watermark_i  (wm),
        .bus          (bus),
        .dma_req_o    (dma),
        .occupancy_o  (occ),
        .flush_busy_o (busy)
    );

    // Behavioural FIFO: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.fifo_rd_en_o) begin
            rd_cnt <= rd_cnt + 1;
            if (fq.size() == 0) underrun <= underrun + 1;
            else                rdata <= fq.pop_front();
        end
        if (wr_en) fq.push_back(wr_data);
        fcnt <= fq.size();
    end

    assign bus.fifo_rd_data_i = rdata;
    assign bus.fifo_empty_i   = (fcnt == 0);
    assign bus.fifo_level_i   = (LW+1)'(fcnt);
    assign bus.m_ready_i      = ready;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic sb_sample();
        if (!reset && bus.m_valid_o && ready) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL sb_extra: unexpected word 0x%08h", bus.m_data_o);
            end else begin
                chk("sb_data", bus.m_data_o, sbq.pop_front());
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        to_neg();
        to_pos();
    endtask

    task automatic wr(input logic [31:0] d, input bit track);
        wr_en   = 1'b1;
        wr_data = d;
        if (track) sbq.push_back(d);
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 80 && sbq.size() != 0; c++) cyc();
        chk(nm, 32'(sbq.size()), 32'd0);
    endtask

    task automatic wait_flush_done(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            to_neg();
            if (!busy) break;
            if (bus.m_valid_o) bad++;
            to_pos();
        end
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_occ"}, 32'(occ), 32'd0);
        chk({nm, "_valid"}, 32'(bad), 32'd0);
        to_pos();
    endtask

    initial begin
        vec_t tbl [8];
        int   rd_base, vcount, first, last, mark;

        tbl[0] = '{1'b1, 5'd0,  1'b0, 6'd12};
        tbl[1] = '{1'b1, 5'd12, 1'b1, 6'd12};
        tbl[2] = '{1'b1, 5'd13, 1'b0, 6'd12};
        tbl[3] = '{1'b1, 5'd1,  1'b1, 6'd12};
        tbl[4] = '{1'b1, 5'd16, 1'b0, 6'd12};
        tbl[5] = '{1'b0, 5'd8,  1'b0, 6'd12};
        tbl[6] = '{1'b1, 5'd8,  1'b1, 6'd12};
        tbl[7] = '{1'b1, 5'd11, 1'b1, 6'd12};

        // Reset and single-word latency.
        to_pos();
        to_pos();
        reset = 1'b0; enable = 1'b1; ready = 1'b1;
        to_neg();
        chk("rst_valid", 32'(bus.m_valid_o), 32'd0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
        chk("rst_dma", 32'(dma), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        to_pos();
        wr(32'hA5A5_0001, 1'b1);
        cyc();
        wr_en = 1'b0;
        to_neg();
        chk("lat_rd_en", 32'(bus.fifo_rd_en_o), 32'd1);
        chk("lat_occ", 32'(occ), 32'd1);
        chk("lat_valid_t", 32'(bus.m_valid_o), 32'd0);
        to_pos();
        to_neg();
        chk("lat_rd_en_t1", 32'(bus.fifo_rd_en_o), 32'd0);
        chk("lat_valid_t1", 32'(bus.m_valid_o), 32'd0);
        to_pos();
        to_neg();
        chk("lat_valid_t2", 32'(bus.m_valid_o), 32'd1);
        chk("lat_data_t2", bus.m_data_o, 32'hA5A5_0001);
        to_pos();
        to_neg();
        chk("lat_occ_end", 32'(occ), 32'd0);
        to_pos();

        // Streaming 16 preloaded words at full rate.
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(32'(i), 1'b1);
            cyc();
        end
        wr_en = 1'b0;
        to_neg();
        chk("stream_preload_occ", 32'(occ), 32'd16);
        to_pos();
        enable = 1'b1;
        rd_base = rd_cnt; vcount = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            to_neg();
            if (bus.m_valid_o) begin
                vcount++;
                if (first < 0) first = c;
                last = c;
            end
            to_pos();
        end
        chk("stream_count", 32'(vcount), 32'd16);
        chk("stream_contig", 32'(last - first + 1), 32'd16);
        chk("stream_reads", 32'(rd_cnt - rd_base), 32'd16);
        chk("stream_sb_left", 32'(sbq.size()), 32'd0);

        // Backpressure: only two reads fill the buffer, head holds.
        ready = 1'b0; enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(32'(i), 1'b1);
            cyc();
        end
        wr_en = 1'b0;
        cyc();
        enable = 1'b1;
        rd_base = rd_cnt;
        repeat (8) cyc();
        to_neg();
        chk("bp_reads", 32'(rd_cnt - rd_base), 32'd2);
        chk("bp_occ", 32'(occ), 32'd16);
        chk("bp_valid", 32'(bus.m_valid_o), 32'd1);
        chk("bp_data", bus.m_data_o, 32'd0);
        to_pos();
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk("bp_hold", bus.m_data_o, 32'd0);
            to_pos();
        end
        for (int c = 0; c < 100 && sbq.size() != 0; c++) begin
            ready = (c % 2 == 0);
            cyc();
        end
        chk("bp_drain", 32'(sbq.size()), 32'd0);
        ready = 1'b1;
        repeat (4) cyc();
        to_neg();
        chk("bp_valid_end", 32'(bus.m_valid_o), 32'd0);
        chk("bp_occ_end", 32'(occ), 32'd0);
        to_pos();

        // Watermark rise timing, then the threshold/enable vector table.
        ready = 1'b0; wm = 5'd8; mark = 0;
        for (int i = 0; i < 12; i++) begin
            wr(32'h200 + 32'(i), 1'b1);
            to_neg();
            if (mark == 1) begin
                chk("wm_rise", 32'(dma), 32'd1);
                mark = 2;
            end else if (mark == 0 && occ == 6'd8) begin
                chk("wm_before", 32'(dma), 32'd0);
                mark = 1;
            end
            to_pos();
        end
        chk("wm_seen", 32'(mark), 32'd2);
        wr_en = 1'b0;
        repeat (4) cyc();
        for (int v = 0; v < 8; v++) begin
            enable = tbl[v].en;
            wm     = tbl[v].wm;
            cyc();
            cyc();
            to_neg();
            chk($sformatf("wm_tbl%0d_dma", v), 32'(dma), 32'(tbl[v].exp_dma));
            chk($sformatf("wm_tbl%0d_occ", v), 32'(occ), 32'(tbl[v].exp_occ));
            to_pos();
        end
        wm = '0; ready = 1'b1;
        drain("wm_drain");

        // Flush with 10 words queued and 2 buffered, plus an upstream write mid-flush.
        ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr(32'h400 + 32'(i), 1'b0);
            cyc();
        end
        wr_en = 1'b0;
        repeat (4) cyc();
        to_neg();
        chk("fl_pre_occ", 32'(occ), 32'd12);
        chk("fl_pre_valid", 32'(bus.m_valid_o), 32'd1);
        to_pos();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wr(32'hDEAD_0000, 1'b0);
        to_neg();
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_valid_drop", 32'(bus.m_valid_o), 32'd0);
        to_pos();
        wr_en = 1'b0;
        wait_flush_done("fl_exit");
        ready = 1'b1;
        wr(32'hBEEF_0001, 1'b1);
        cyc();
        wr_en = 1'b0;
        repeat (6) cyc();
        chk("fl_after_word", 32'(sbq.size()), 32'd0);

        // Reset while flushing.
        ready = 1'b0; wm = 5'd1;
        for (int i = 0; i < 6; i++) begin
            wr(32'h500 + 32'(i), 1'b0);
            cyc();
        end
        wr_en = 1'b0;
        repeat (3) cyc();
        to_neg();
        chk("rf_pre_dma", 32'(dma), 32'd1);
        to_pos();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        to_neg();
        chk("rf_busy", 32'(busy), 32'd1);
        to_pos();
        reset = 1'b1;
        cyc();
        reset = 1'b0; enable = 1'b0; wm = '0;
        to_neg();
        chk("rf_busy0", 32'(busy), 32'd0);
        chk("rf_valid0", 32'(bus.m_valid_o), 32'd0);
        chk("rf_dma0", 32'(dma), 32'd0);
        chk("rf_rd_en0", 32'(bus.fifo_rd_en_o), 32'd0);
        chk("rf_occ", 32'(occ), 32'(fcnt));
        to_pos();
        enable = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_flush_done("rf_clean");

        // Enable dropped with a read in flight.
        ready = 1'b1;
        cyc();
        rd_base = rd_cnt;
        wr(32'h300, 1'b1);
        cyc();
        wr(32'h301, 1'b0);
        enable = 1'b0;
        to_neg();
        chk("ed_rd_en", 32'(bus.fifo_rd_en_o), 32'd1);
        to_pos();
        wr(32'h302, 1'b0);
        cyc();
        wr_en = 1'b0;
        repeat (8) cyc();
        chk("ed_reads", 32'(rd_cnt - rd_base), 32'd1);
        chk("ed_word_out", 32'(sbq.size()), 32'd0);
        to_neg();
        chk("ed_occ", 32'(occ), 32'd2);
        chk("ed_valid", 32'(bus.m_valid_o), 32'd0);
        to_pos();
        sbq.push_back(32'h301);
        sbq.push_back(32'h302);
        enable = 1'b1;
        drain("ed_drain");

        chk("fifo_underrun", 32'(underrun), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
